// File: rtl/ocm_port_arbiter.sv
// ocm_port_arbiter: display-priority OCM port A arbiter with render starvation override (ports: MAIN_CLK/RESET, display req/gnt/rdata, render valid/ready/rdata, OCM port A, DISP_MISS_CNT)
module ocm_port_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        MAIN_CLK,
  input  logic        RESET,
  input  logic        DISP_REQ,
  input  logic [15:0] DISP_ADDR,
  output logic        DISP_GNT,
  output logic        DISP_RVALID,
  output logic [15:0] DISP_RDATA,
  input  logic        REND_VALID,
  input  logic        REND_WE,
  input  logic [15:0] REND_ADDR,
  input  logic [15:0] REND_WDATA,
  output logic        REND_READY,
  output logic        REND_RVALID,
  output logic [15:0] REND_RDATA,
  output logic [15:0] OCM_ADDR_A,
  output logic [15:0] OCM_DATAIN_A,
  output logic        OCM_WE_A,
  input  logic [15:0] OCM_DATAOUT_A,
  output logic [15:0] DISP_MISS_CNT
);
  localparam logic [0:0] DISP_PRI = 1'b0;
  localparam logic [0:0] REND_FORCE = 1'b1;
  localparam logic [7:0] LIM = 8'(STARVE_LIMIT);
  logic [0:0] state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [15:0] miss_q, miss_d;
  logic disp_rv_q, rend_rv_q;
  always_comb begin
    DISP_GNT = !RESET && DISP_REQ && (state_q == DISP_PRI || !REND_VALID);
    REND_READY = !RESET && REND_VALID && (state_q == REND_FORCE || !DISP_REQ);
    OCM_ADDR_A = DISP_GNT ? DISP_ADDR : REND_READY ? REND_ADDR : 16'h0000;
    OCM_DATAIN_A = REND_READY ? REND_WDATA : 16'h0000;
    OCM_WE_A = REND_READY && REND_WE;
    wait_d = (!REND_VALID || REND_READY) ? 8'd0 : (wait_q == 8'hFF) ? 8'hFF : wait_q + 8'd1;
    state_d = (state_q == REND_FORCE) ? DISP_PRI : (wait_d >= LIM) ? REND_FORCE : DISP_PRI;
    miss_d = (DISP_REQ && !DISP_GNT && miss_q != 16'hFFFF) ? miss_q + 16'd1 : miss_q;
    DISP_RVALID = disp_rv_q && !RESET;
    REND_RVALID = rend_rv_q && !RESET;
    DISP_MISS_CNT = RESET ? 16'h0000 : miss_q;
    DISP_RDATA = OCM_DATAOUT_A;
    REND_RDATA = OCM_DATAOUT_A;
  end
  always_ff @(posedge MAIN_CLK) begin
    if (RESET) begin
      state_q <= DISP_PRI;
      wait_q <= 8'd0;
      miss_q <= 16'h0000;
      disp_rv_q <= 1'b0;
      rend_rv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      miss_q <= miss_d;
      disp_rv_q <= DISP_GNT;
      rend_rv_q <= REND_READY && !REND_WE;
    end
  end
endmodule

// File: tb/tb_ocm_port_arbiter.sv
// tb_ocm_port_arbiter: directed self-checking bench for ocm_port_arbiter
module tb_ocm_port_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic disp_req, rend_valid, rend_we;
  logic [15:0] disp_addr, rend_addr, rend_wdata, ocm_dout;
  logic disp_gnt, disp_rvalid, rend_ready, rend_rvalid, ocm_we;
  logic [15:0] disp_rdata, rend_rdata, ocm_addr, ocm_din, miss_cnt;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  ocm_port_arbiter #(.STARVE_LIMIT(8)) dut (
    .MAIN_CLK(clk), .RESET(rst),
    .DISP_REQ(disp_req), .DISP_ADDR(disp_addr), .DISP_GNT(disp_gnt),
    .DISP_RVALID(disp_rvalid), .DISP_RDATA(disp_rdata),
    .REND_VALID(rend_valid), .REND_WE(rend_we), .REND_ADDR(rend_addr),
    .REND_WDATA(rend_wdata), .REND_READY(rend_ready), .REND_RVALID(rend_rvalid),
    .REND_RDATA(rend_rdata), .OCM_ADDR_A(ocm_addr), .OCM_DATAIN_A(ocm_din),
    .OCM_WE_A(ocm_we), .OCM_DATAOUT_A(ocm_dout), .DISP_MISS_CNT(miss_cnt)
  );
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    disp_req = 1'b1;
    disp_addr = 16'h0077;
    rend_valid = 1'b1;
    rend_we = 1'b1;
    rend_addr = 16'h0099;
    rend_wdata = 16'h1234;
    ocm_dout = 16'h0000;
    tick();
    tick();
    chk("rst_gnt", 16'(disp_gnt), 16'h0);
    chk("rst_ready", 16'(rend_ready), 16'h0);
    chk("rst_we", 16'(ocm_we), 16'h0);
    chk("rst_drv", 16'(disp_rvalid), 16'h0);
    chk("rst_rrv", 16'(rend_rvalid), 16'h0);
    chk("rst_miss", miss_cnt, 16'h0000);
    rst = 1'b0;
    disp_req = 1'b0;
    rend_valid = 1'b0;
    #1;
    chk("idle_we", 16'(ocm_we), 16'h0);
    chk("idle_addr", ocm_addr, 16'h0000);
    chk("idle_din", ocm_din, 16'h0000);
    chk("idle_gnt", 16'(disp_gnt), 16'h0);
    tick();
    chk("idle_drv", 16'(disp_rvalid), 16'h0);
    chk("idle_rrv", 16'(rend_rvalid), 16'h0);
    disp_req = 1'b1;
    disp_addr = 16'h0010;
    rend_valid = 1'b1;
    rend_we = 1'b1;
    rend_addr = 16'h5555;
    rend_wdata = 16'h1111;
    #1;
    chk("pri_gnt", 16'(disp_gnt), 16'h1);
    chk("pri_ready", 16'(rend_ready), 16'h0);
    chk("pri_we", 16'(ocm_we), 16'h0);
    chk("pri_addr", ocm_addr, 16'h0010);
    tick();
    disp_req = 1'b0;
    rend_valid = 1'b0;
    ocm_dout = 16'hA5A5;
    #1;
    chk("pri_drv", 16'(disp_rvalid), 16'h1);
    chk("pri_rdata", disp_rdata, 16'hA5A5);
    chk("pri_rrv", 16'(rend_rvalid), 16'h0);
    tick();
    chk("pri_drv_off", 16'(disp_rvalid), 16'h0);
    rend_valid = 1'b1;
    rend_we = 1'b1;
    rend_addr = 16'h1234;
    rend_wdata = 16'hBEEF;
    #1;
    chk("wr_ready", 16'(rend_ready), 16'h1);
    chk("wr_gnt", 16'(disp_gnt), 16'h0);
    chk("wr_we", 16'(ocm_we), 16'h1);
    chk("wr_addr", ocm_addr, 16'h1234);
    chk("wr_din", ocm_din, 16'hBEEF);
    tick();
    rend_we = 1'b0;
    #1;
    chk("rd_ready", 16'(rend_ready), 16'h1);
    chk("rd_we", 16'(ocm_we), 16'h0);
    chk("rd_addr", ocm_addr, 16'h1234);
    chk("wr_no_rrv", 16'(rend_rvalid), 16'h0);
    tick();
    rend_valid = 1'b0;
    ocm_dout = 16'hBEEF;
    #1;
    chk("rd_rrv", 16'(rend_rvalid), 16'h1);
    chk("rd_rdata", rend_rdata, 16'hBEEF);
    tick();
    disp_req = 1'b1;
    disp_addr = 16'h0020;
    rend_valid = 1'b1;
    rend_we = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("starve_gnt%0d", k), 16'(disp_gnt), 16'h1);
      chk($sformatf("starve_ready%0d", k), 16'(rend_ready), 16'h0);
      tick();
    end
    chk("force_ready", 16'(rend_ready), 16'h1);
    chk("force_gnt", 16'(disp_gnt), 16'h0);
    chk("force_miss_pre", miss_cnt, 16'h0000);
    tick();
    chk("regain_gnt", 16'(disp_gnt), 16'h1);
    chk("regain_ready", 16'(rend_ready), 16'h0);
    chk("regain_miss", miss_cnt, 16'h0001);
    tick();
    rend_valid = 1'b0;
    disp_addr = 16'h0042;
    #1;
    chk("n_gnt", 16'(disp_gnt), 16'h1);
    tick();
    rst = 1'b1;
    #1;
    chk("rstmid_drv", 16'(disp_rvalid), 16'h0);
    chk("rstmid_miss", miss_cnt, 16'h0000);
    chk("rstmid_gnt", 16'(disp_gnt), 16'h0);
    tick();
    rst = 1'b0;
    disp_req = 1'b0;
    #1;
    chk("post_rst_drv", 16'(disp_rvalid), 16'h0);
    chk("post_rst_miss", miss_cnt, 16'h0000);
    force dut.miss_q = 16'hFFFE;
    #1;
    release dut.miss_q;
    chk("sat_preload", miss_cnt, 16'hFFFE);
    disp_req = 1'b1;
    rend_valid = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    chk("sat_reach", miss_cnt, 16'hFFFF);
    for (int k = 0; k < 9; k++) tick();
    chk("sat_hold", miss_cnt, 16'hFFFF);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ocm_port_arbiter.md
OCM_PORT_ARBITER -- requirements
Module: ocm_port_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 8, giving the render wait cycles (range 1..255) before render is forced ahead of display.
REQ-002 SHALL have port MAIN_CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port DISP_REQ, input, 1 bit: display read request, held until granted.
REQ-005 SHALL have port DISP_ADDR, input, 16 bits: display read address.
REQ-006 SHALL have port DISP_GNT, output, 1 bit: display access issued to OCM this cycle.
REQ-007 SHALL have port DISP_RVALID, output, 1 bit: DISP_RDATA valid.
REQ-008 SHALL have port DISP_RDATA, output, 16 bits: display read data.
REQ-009 SHALL have port REND_VALID, input, 1 bit: render request valid.
REQ-010 SHALL have port REND_WE, input, 1 bit: 1 = write, 0 = read.
REQ-011 SHALL have port REND_ADDR, input, 16 bits: render address.
REQ-012 SHALL have port REND_WDATA, input, 16 bits: render write data.
REQ-013 SHALL have port REND_READY, output, 1 bit: render request accepted this cycle.
REQ-014 SHALL have port REND_RVALID, output, 1 bit: REND_RDATA valid.
REQ-015 SHALL have port REND_RDATA, output, 16 bits: render read data.
REQ-016 SHALL have port OCM_ADDR_A, output, 16 bits: memory port A address.
REQ-017 SHALL have port OCM_DATAIN_A, output, 16 bits: memory port A write data.
REQ-018 SHALL have port OCM_WE_A, output, 1 bit: memory port A write enable.
REQ-019 SHALL have port OCM_DATAOUT_A, input, 16 bits: memory port A read data, registered in memory (valid 1 cycle after address).
REQ-020 SHALL have port DISP_MISS_CNT, output, 16 bits: saturating count of cycles with DISP_REQ=1 and DISP_GNT=0.

Function
REQ-021 SHALL issue at most one access to port A per cycle; DISP_GNT and REND_READY SHALL never both be 1.
REQ-022 SHALL implement two states: DISP_PRI and REND_FORCE.
REQ-023 In DISP_PRI: DISP_REQ=1 -> DISP_GNT=1; else REND_VALID=1 -> REND_READY=1.
REQ-024 In REND_FORCE: REND_VALID=1 -> REND_READY=1 and DISP_GNT=0; else DISP_GNT=DISP_REQ.
REQ-025 SHALL keep 8-bit WAIT_CNT: cleared on render transfer (REND_VALID & REND_READY) or REND_VALID=0; +1 when REND_VALID=1 & REND_READY=0; saturates at 255.
REQ-026 DISP_PRI -> REND_FORCE when next WAIT_CNT >= STARVE_LIMIT; REND_FORCE -> DISP_PRI after exactly one cycle.
REQ-027 Grant decode SHALL be combinational from current state and inputs; no grant when RESET=1.
REQ-028 Display grant: OCM_ADDR_A=DISP_ADDR, OCM_WE_A=0.
REQ-029 Render grant: OCM_ADDR_A=REND_ADDR, OCM_DATAIN_A=REND_WDATA, OCM_WE_A=REND_WE.
REQ-030 No grant: OCM_WE_A=0, OCM_ADDR_A=0, OCM_DATAIN_A=0.
REQ-031 Read latency SHALL be 1 cycle: DISP_RVALID registered from DISP_GNT; REND_RVALID registered from render read transfer.
REQ-032 DISP_RDATA and REND_RDATA SHALL both be driven combinationally from OCM_DATAOUT_A; meaningful only while the matching RVALID=1.
REQ-033 Render write SHALL produce no RVALID.
REQ-034 DISP_MISS_CNT SHALL hold at 0xFFFF once reached.
REQ-035 Requests SHALL be ignored in the cycle RESET=1.
REQ-036 A transfer in the cycle before RESET asserts SHALL produce RVALID=0 in the cycle RESET is high; RESET dominates.

Reset
REQ-037 While RESET=1 at a clock edge, the block SHALL load state=DISP_PRI, WAIT_CNT=0, DISP_RVALID=0, REND_RVALID=0, DISP_MISS_CNT=0.
REQ-038 While RESET=1, DISP_GNT=0, REND_READY=0 and OCM_WE_A=0.

Verification
REQ-039 Display priority: DISP_REQ=1 addr 0x0010, REND_VALID=1 write -> DISP_GNT=1, REND_READY=0, OCM_WE_A=0, OCM_ADDR_A=0x0010; DISP_RVALID=1 next cycle.
REQ-040 Starvation, STARVE_LIMIT=8: DISP_REQ and REND_VALID held at 1 -> REND_READY=1 exactly on the 9th cycle; DISP_MISS_CNT increments by 1; display regains grant next cycle.
REQ-041 Render write then read: write 0xBEEF to 0x1234 with no display request; read 0x1234 next cycle -> REND_RVALID=1 one cycle later with REND_RDATA=0xBEEF.
REQ-042 Idle: all requests 0 -> OCM_WE_A=0, OCM_ADDR_A=0, no RVALID.
REQ-043 Reset mid-read: display grant at cycle N, RESET=1 at cycle N+1 -> DISP_RVALID=0 at N+1 and DISP_MISS_CNT=0.
REQ-044 Saturation: force DISP_MISS_CNT to 65535 missed cycles -> stays 0xFFFF with no wrap.
